pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. Compares register sources in D against pending destinations in E/M/W using Tuse/Tnew, produces stall/bubble enables for the F/D and D/E pipeline registers and forwarding selects for D and E operands. Owns a multiply/divide busy timer that holds any MDU-using instruction in D until HI/LO is ready. Sits beside the datapath and drives the enables of PC, RegFD, RegDE and the operand muxes.

## Interface
- MULT_CYC, 5, busy cycles after a mult/multu issues
- DIV_CYC, 10, busy cycles after a div/divu issues
- CNT_W, 4, timer width; must hold max(MULT_CYC, DIV_CYC)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- rs_D, rt_D  in  5  D-stage source register addresses
- tuse_rs_D, tuse_rt_D  in  2  cycles until use; 3 = operand unused
- rs_E, rt_E  in  5  E-stage source addresses
- wa_E, wa_M, wa_W  in  5  destination address per stage; 0 = no write
- tnew_E, tnew_M  in  2  cycles until result ready in that stage (W is always 0)
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- start_E  in  1  mult/multu/div/divu valid in E this cycle
- is_div_E  in  1  qualifies start_E: 1 = div, 0 = mult
- en_PC, en_FD  out  1  write enables for PC and F/D register
- clr_DE  out  1  load a bubble (all-zero) into D/E register
- fwd_rs_D, fwd_rt_D  out  2  D operand select: 0 regfile, 1 from E, 2 from M
- fwd_rs_E, fwd_rt_E  out  2  E operand select: 0 D/E value, 1 from M, 2 from W
- mdu_busy  out  1  registered; timer running

## Operation
- Data stall: stall_rs = rs_D≠0 and ((rs_D==wa_E and tuse_rs_D<tnew_E) or (rs_D==wa_M and tuse_rs_D<tnew_M)); stall_rt same on rt. tuse=3 never stalls.
- MD stall: md_use_D and (start_E or mdu_busy).
- stall = data stall or MD stall → en_PC=0, en_FD=0, clr_DE=1; otherwise 1,1,0.
- D forwarding, per operand, addr≠0: match wa_E with tnew_E==0 → 1; else match wa_M with tnew_M==0 → 2; else 0. E newer than M takes priority.
- E forwarding: match wa_M (tnew_M==0) → 1; else match wa_W → 2; else 0; addr 0 → 0.
- Timer FSM, states IDLE/BUSY: IDLE + start_E → BUSY, cnt = is_div_E ? DIV_CYC : MULT_CYC. BUSY: cnt decrements each cycle; cnt==1 → IDLE. mdu_busy = (state==BUSY).
- start_E while BUSY is illegal (MD stall prevents it): ignored, counter not reloaded; bench flags it as an assertion.
- Address 0 never stalls nor forwards.

## Timing
- Reset: state IDLE, cnt 0, mdu_busy 0. All other outputs combinational; with all inputs 0: en_PC=1, en_FD=1, clr_DE=0, all fwd=0.
- Reset mid-BUSY: next cycle IDLE, mdu_busy 0; no pending stall remains.
- start_E at cycle t: MD stall at t (combinational); mdu_busy high t+1..t+N; MD stall released at t+N+1.
- Stall/forward outputs are zero-latency from inputs in the same cycle; no registered path other than timer.
- Data stall and MD stall concurrent: single stall, same outputs.

## Structure
- Shared package: TUSE_NONE=3, FWD_* select encodings, MULT_CYC/DIV_CYC defaults, FSM state encoding.
- Sub-module mdu_busy_timer (IDLE/BUSY FSM + down-counter, outputs mdu_busy); remainder is the comparator/priority logic in the top.

## Test plan
- Reset, all inputs 0 → en_PC=1, en_FD=1, clr_DE=0, fwd all 0, mdu_busy=0.
- lw $8 in E (wa_E=8, tnew_E=2), D rs_D=8, tuse_rs_D=0 → stall one cycle; next cycle wa_M=8, tnew_M=1 → still stall; then tnew_M=0 → no stall, fwd_rs_D=2.
- wa_E=9 tnew_E=0 and wa_M=9 tnew_M=0, rs_D=9 → fwd_rs_D=1 (E priority); rs_D=0 with wa_E=0 → fwd 0, no stall.
- start_E=1, is_div_E=0 at t, md_use_D=1 throughout → clr_DE=1 for t..t+5, released at t+6; mdu_busy high t+1..t+5.
- div at t, reset asserted at t+4 → mdu_busy 0 from t+5, MD stall gone.
- rs_E=4, wa_M=4 tnew_M=0, wa_W=4 → fwd_rs_E=1; wa_M=5 → fwd_rs_E=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared constants and types for the pipeline hazard controller:
//   Tuse "operand unused" marker, forwarding select encodings for the D and
//   E operand muxes, default MDU latencies and the busy-timer state encoding.
package pipe_hazard_ctrl_pkg;

  // Tuse value meaning the instruction does not read this operand.
  localparam logic [1:0] TUSE_NONE  = 2'd3;

  // D-stage operand mux selects.
  localparam logic [1:0] FWD_D_RF   = 2'd0;  // register file
  localparam logic [1:0] FWD_D_E    = 2'd1;  // result in E
  localparam logic [1:0] FWD_D_M    = 2'd2;  // result in M

  // E-stage operand mux selects.
  localparam logic [1:0] FWD_E_DE   = 2'd0;  // value latched in D/E
  localparam logic [1:0] FWD_E_M    = 2'd1;  // result in M
  localparam logic [1:0] FWD_E_W    = 2'd2;  // result in W

  // Default HI/LO latencies after issue.
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // A source hits a pending destination only for a real register;
  // $0 is hard-wired and never produces a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the hazard-controller signals exchanged with the datapath.
//   master : datapath side (drives register addresses / Tuse / Tnew / MDU
//            issue info, consumes enables and forwarding selects)
//   slave  : hazard controller side
//   Signals:
//     rs_D, rt_D, tuse_rs_D, tuse_rt_D  D-stage sources and their Tuse
//     rs_E, rt_E                        E-stage sources
//     wa_E, wa_M, wa_W, tnew_E, tnew_M  pending destinations and Tnew
//     md_use_D, start_E, is_div_E       MDU usage / issue
//     en_PC, en_FD, clr_DE              pipeline register controls
//     fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E  operand mux selects
//     mdu_busy                          registered MDU busy flag
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [4:0] rs_E;
  logic [4:0] rt_E;
  logic [4:0] wa_E;
  logic [4:0] wa_M;
  logic [4:0] wa_W;
  logic [1:0] tnew_E;
  logic [1:0] tnew_M;
  logic       md_use_D;
  logic       start_E;
  logic       is_div_E;

  logic       en_PC;
  logic       en_FD;
  logic       clr_DE;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [1:0] fwd_rs_E;
  logic [1:0] fwd_rt_E;
  logic       mdu_busy;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, rs_E, rt_E,
    output wa_E, wa_M, wa_W, tnew_E, tnew_M,
    output md_use_D, start_E, is_div_E,
    input  en_PC, en_FD, clr_DE,
    input  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, mdu_busy
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, rs_E, rt_E,
    input  wa_E, wa_M, wa_W, tnew_E, tnew_M,
    input  md_use_D, start_E, is_div_E,
    output en_PC, en_FD, clr_DE,
    output fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, mdu_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// mdu_busy_timer
//   Tracks how long HI/LO stay unavailable after a mult/div issues in E.
//   IDLE --start_i--> BUSY with the counter loaded with the op latency;
//   the counter steps down each cycle and the FSM returns to IDLE after the
//   cycle in which it reads 1, so busy_o is high for exactly N cycles.
//   Ports:
//     clk, reset  clock / synchronous active-high reset
//     start_i     mult/multu/div/divu valid in E
//     is_div_i    1 = divide latency, 0 = multiply latency
//     busy_o      registered, high while the timer runs
module mdu_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_BUSY;
          cnt_d   = is_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
      end
      ST_BUSY: begin
        // A start while busy cannot legally occur (D holds MDU ops), so it
        // is ignored rather than reloading the counter.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall controller for the five-stage MIPS pipeline.
//   Compares D-stage sources with destinations pending in E/M/W using the
//   Tuse/Tnew model, stalls F/D and bubbles D/E when an operand cannot be
//   forwarded in time or when an MDU instruction would touch HI/LO early,
//   and produces the forwarding selects for the D and E operand muxes.
//   Ports:
//     clk, reset  clock / synchronous active-high reset (timer only)
//     hz          pipe_hazard_ctrl_if.slave: addresses, Tuse/Tnew, MDU
//                 issue in; en_PC, en_FD, clr_DE, forwarding selects and
//                 mdu_busy out. Everything except mdu_busy is combinational.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  logic mdu_busy_w;
  logic stall_rs, stall_rt, stall_data, stall_md, stall;

  mdu_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (hz.start_E),
    .is_div_i (hz.is_div_E),
    .busy_o   (mdu_busy_w)
  );

  // D operand select: the younger producer (E) wins over M when both hit.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                           input logic [4:0] wa_e,
                                           input logic [1:0] tnew_e,
                                           input logic [4:0] wa_m,
                                           input logic [1:0] tnew_m);
    if (reg_hit(src, wa_e) && (tnew_e == 2'd0))
      return FWD_D_E;
    else if (reg_hit(src, wa_m) && (tnew_m == 2'd0))
      return FWD_D_M;
    else
      return FWD_D_RF;
  endfunction

  // E operand select: M is younger than W. W results are always ready.
  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                           input logic [4:0] wa_m,
                                           input logic [1:0] tnew_m,
                                           input logic [4:0] wa_w);
    if (reg_hit(src, wa_m) && (tnew_m == 2'd0))
      return FWD_E_M;
    else if (reg_hit(src, wa_w))
      return FWD_E_W;
    else
      return FWD_E_DE;
  endfunction

  // Stall when the producer will not be ready before the consumer needs it.
  // Tuse of TUSE_NONE (3) is never below a 2-bit Tnew, so unused operands
  // fall out of the comparison naturally.
  assign stall_rs = (reg_hit(hz.rs_D, hz.wa_E) && (hz.tuse_rs_D < hz.tnew_E)) ||
                    (reg_hit(hz.rs_D, hz.wa_M) && (hz.tuse_rs_D < hz.tnew_M));
  assign stall_rt = (reg_hit(hz.rt_D, hz.wa_E) && (hz.tuse_rt_D < hz.tnew_E)) ||
                    (reg_hit(hz.rt_D, hz.wa_M) && (hz.tuse_rt_D < hz.tnew_M));

  assign stall_data = stall_rs || stall_rt;
  // Cover the issue cycle too: the timer only goes busy one cycle later.
  assign stall_md   = hz.md_use_D && (hz.start_E || mdu_busy_w);
  assign stall      = stall_data || stall_md;

  assign hz.en_PC    = !stall;
  assign hz.en_FD    = !stall;
  assign hz.clr_DE   = stall;
  assign hz.mdu_busy = mdu_busy_w;

  assign hz.fwd_rs_D = fwd_d_sel(hz.rs_D, hz.wa_E, hz.tnew_E, hz.wa_M, hz.tnew_M);
  assign hz.fwd_rt_D = fwd_d_sel(hz.rt_D, hz.wa_E, hz.tnew_E, hz.wa_M, hz.tnew_M);
  assign hz.fwd_rs_E = fwd_e_sel(hz.rs_E, hz.wa_M, hz.tnew_M, hz.wa_W);
  assign hz.fwd_rt_E = fwd_e_sel(hz.rt_E, hz.wa_M, hz.tnew_M, hz.wa_W);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if hif();

  pipe_hazard_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issuing an MDU op while the timer is busy is illegal.
  always @(posedge clk) begin
    if (!reset && hif.start_E && hif.mdu_busy) begin
      errors = errors + 1;
      $display("FAIL start_while_busy: start_E=%0b mdu_busy=%0b required no overlap",
               hif.start_E, hif.mdu_busy);
    end
  end

  task automatic clear_inputs();
    hif.rs_D = 0; hif.rt_D = 0; hif.tuse_rs_D = 0; hif.tuse_rt_D = 0;
    hif.rs_E = 0; hif.rt_E = 0;
    hif.wa_E = 0; hif.wa_M = 0; hif.wa_W = 0;
    hif.tnew_E = 0; hif.tnew_M = 0;
    hif.md_use_D = 0; hif.start_E = 0; hif.is_div_E = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (hif.mdu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b want 0", hif.mdu_busy);
    end
    checks++;
    if ({hif.en_PC, hif.en_FD, hif.clr_DE} !== 3'b110) begin
      errors++; $display("FAIL reset_ctrl: got %b want 110", {hif.en_PC, hif.en_FD, hif.clr_DE});
    end
    checks++;
    if ({hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E} !== 8'h00) begin
      errors++; $display("FAIL reset_fwd: got %h want 00",
                         {hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E});
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    // lw $8 in E, D uses $8 immediately
    hif.wa_E = 8; hif.tnew_E = 2; hif.rs_D = 8; hif.tuse_rs_D = 0;
    #1;
    checks++;
    if ({hif.en_PC, hif.en_FD, hif.clr_DE} !== 3'b001) begin
      errors++; $display("FAIL lu_stall_E: got %b want 001", {hif.en_PC, hif.en_FD, hif.clr_DE});
    end
    // lw now in M, still not ready
    hif.wa_E = 0; hif.tnew_E = 0; hif.wa_M = 8; hif.tnew_M = 1;
    #1;
    checks++;
    if ({hif.en_PC, hif.en_FD, hif.clr_DE} !== 3'b001) begin
      errors++; $display("FAIL lu_stall_M: got %b want 001", {hif.en_PC, hif.en_FD, hif.clr_DE});
    end
    hif.tnew_M = 0;
    #1;
    checks++;
    if ({hif.en_PC, hif.en_FD, hif.clr_DE} !== 3'b110) begin
      errors++; $display("FAIL lu_release: got %b want 110", {hif.en_PC, hif.en_FD, hif.clr_DE});
    end
    checks++;
    if (hif.fwd_rs_D !== 2'd2) begin
      errors++; $display("FAIL lu_fwd_rs_D: got %0d want 2", hif.fwd_rs_D);
    end
    // rt side: tuse 1 vs tnew_E 2 stalls
    clear_inputs();
    hif.wa_E = 12; hif.tnew_E = 2; hif.rt_D = 12; hif.tuse_rt_D = 1;
    #1;
    checks++;
    if (hif.clr_DE !== 1'b1) begin
      errors++; $display("FAIL rt_stall: got %0b want 1", hif.clr_DE);
    end
    // operand unused never stalls
    hif.tuse_rt_D = 2'd3;
    #1;
    checks++;
    if (hif.clr_DE !== 1'b0) begin
      errors++; $display("FAIL tuse_none: got %0b want 0", hif.clr_DE);
    end
    // tuse equal to tnew is fine; not yet forwardable from E
    hif.tuse_rt_D = 2'd2;
    #1;
    checks++;
    if ({hif.clr_DE, hif.fwd_rt_D} !== 3'b000) begin
      errors++; $display("FAIL tuse_eq_tnew: got %b want 000", {hif.clr_DE, hif.fwd_rt_D});
    end
  endtask

  task automatic test_d_fwd();
    clear_inputs();
    hif.wa_E = 9; hif.tnew_E = 0; hif.wa_M = 9; hif.tnew_M = 0;
    hif.rs_D = 9; hif.rt_D = 9; hif.tuse_rs_D = 0; hif.tuse_rt_D = 1;
    #1;
    checks++;
    if ({hif.fwd_rs_D, hif.fwd_rt_D} !== 4'b0101) begin
      errors++; $display("FAIL d_fwd_E_prio: got %b want 0101", {hif.fwd_rs_D, hif.fwd_rt_D});
    end
    checks++;
    if (hif.clr_DE !== 1'b0) begin
      errors++; $display("FAIL d_fwd_nostall: got %0b want 0", hif.clr_DE);
    end
    // $0 never forwards or stalls
    clear_inputs();
    hif.rs_D = 0; hif.wa_E = 0; hif.tnew_E = 2; hif.wa_M = 0; hif.tnew_M = 2;
    #1;
    checks++;
    if ({hif.fwd_rs_D, hif.clr_DE} !== 3'b000) begin
      errors++; $display("FAIL d_zero_reg: got %b want 000", {hif.fwd_rs_D, hif.clr_DE});
    end
  endtask

  task automatic test_e_fwd();
    clear_inputs();
    hif.rs_E = 4; hif.wa_M = 4; hif.tnew_M = 0; hif.wa_W = 4;
    #1;
    checks++;
    if (hif.fwd_rs_E !== 2'd1) begin
      errors++; $display("FAIL e_fwd_M: got %0d want 1", hif.fwd_rs_E);
    end
    hif.wa_M = 5;
    #1;
    checks++;
    if (hif.fwd_rs_E !== 2'd2) begin
      errors++; $display("FAIL e_fwd_W: got %0d want 2", hif.fwd_rs_E);
    end
    // M result not ready yet falls back to W
    hif.rt_E = 7; hif.wa_M = 7; hif.tnew_M = 1; hif.wa_W = 7;
    #1;
    checks++;
    if (hif.fwd_rt_E !== 2'd2) begin
      errors++; $display("FAIL e_fwd_M_notready: got %0d want 2", hif.fwd_rt_E);
    end
    hif.rt_E = 0; hif.wa_M = 0; hif.tnew_M = 0; hif.wa_W = 0;
    #1;
    checks++;
    if (hif.fwd_rt_E !== 2'd0) begin
      errors++; $display("FAIL e_fwd_zero: got %0d want 0", hif.fwd_rt_E);
    end
  endtask

  task automatic test_mult_timer();
    clear_inputs();
    @(posedge clk);
    #1;
    hif.md_use_D = 1; hif.start_E = 1; hif.is_div_E = 0;
    @(negedge clk);  // cycle t
    checks++;
    if ({hif.clr_DE, hif.mdu_busy} !== 2'b10) begin
      errors++; $display("FAIL mult_t0: got %b want 10", {hif.clr_DE, hif.mdu_busy});
    end
    @(posedge clk);
    #1 hif.start_E = 0;
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] exp_v;
      exp_v = (k <= 5) ? 2'b11 : 2'b00;
      @(negedge clk);
      checks++;
      if ({hif.clr_DE, hif.mdu_busy} !== exp_v) begin
        errors++; $display("FAIL mult_t%0d: got %b want %b", k, {hif.clr_DE, hif.mdu_busy}, exp_v);
      end
      @(posedge clk);
      #1;
    end
    // data stall together with MD stall gives the same single stall
    hif.start_E = 1; hif.is_div_E = 0;
    hif.wa_E = 3; hif.tnew_E = 2; hif.rs_D = 3; hif.tuse_rs_D = 0;
    #1;
    checks++;
    if ({hif.en_PC, hif.en_FD, hif.clr_DE} !== 3'b001) begin
      errors++; $display("FAIL concurrent_stall: got %b want 001", {hif.en_PC, hif.en_FD, hif.clr_DE});
    end
    @(posedge clk);
    #1 hif.start_E = 0;
    repeat (6) @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic test_div_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    hif.md_use_D = 1; hif.start_E = 1; hif.is_div_E = 1;
    @(posedge clk);  // end of cycle t
    #1 hif.start_E = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (hif.mdu_busy !== 1'b1) begin
        errors++; $display("FAIL div_busy_t%0d: got %0b want 1", k, hif.mdu_busy);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;  // cycle t+4
    @(negedge clk);
    checks++;
    if (hif.mdu_busy !== 1'b1) begin
      errors++; $display("FAIL div_busy_t4: got %0b want 1", hif.mdu_busy);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);  // cycle t+5
    checks++;
    if ({hif.mdu_busy, hif.clr_DE} !== 2'b00) begin
      errors++; $display("FAIL div_after_reset: got %b want 00", {hif.mdu_busy, hif.clr_DE});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (hif.mdu_busy !== 1'b0) begin
      errors++; $display("FAIL div_stays_idle: got %0b want 0", hif.mdu_busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_d_fwd();
    test_e_fwd();
    test_mult_timer();
    test_div_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
